// File: rtl/ser_pkg.sv
// Shared types and helpers for the UART TX serializer (ser_shift_ctrl).
package ser_pkg;

  localparam int unsigned MAX_DATA_WIDTH = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  // A zero length still sends one bit; lengths beyond the register are cut to its width.
  function automatic int unsigned clamp_len(input int unsigned word_len,
                                            input int unsigned data_width);
    int unsigned len;
    if (word_len == 32'd0) begin
      len = 32'd1;
    end else if (word_len > data_width) begin
      len = data_width;
    end else begin
      len = word_len;
    end
    return len;
  endfunction

  function automatic logic masked_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                         input int unsigned len);
    logic par;
    par = 1'b0;
    for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) begin
      if (i < len) begin
        par = par ^ data[i];
      end else begin
        par = par;
      end
    end
    return par;
  endfunction

endpackage

// File: rtl/ser_len_align.sv
// Load-word alignment: MSB-first words are left-justified so bit LEN-1 lands on the MSB.
module ser_len_align
  import ser_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNTR_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CNTR_WIDTH-1:0] len,
  input  logic                  msb_first,
  output logic [DATA_WIDTH-1:0] load_word
);

  logic [CNTR_WIDTH-1:0] lshift_s;

  // Justify toward the end the shift register emits from.
  always_comb begin
    lshift_s = CNTR_WIDTH'(DATA_WIDTH) - len;
    if (msb_first) begin
      load_word = data_in << lshift_s;
    end else begin
      load_word = data_in;
    end
  end

endmodule

// File: rtl/ser_shift_ctrl.sv
// UART TX serializer: valid/ready word load, one bit per ser_en strobe, ser_done after last bit.
// Optional parity output enabled with `define SER_PARITY_EN.
module ser_shift_ctrl
  import ser_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter int   CNTR_WIDTH = 4,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [CNTR_WIDTH-1:0] word_len,
  input  logic                  msb_first,
  input  logic                  ser_en,
`ifdef SER_PARITY_EN
  input  logic                  par_odd,
  output logic                  par_bit,
`endif
  output logic                  ser_data,
  output logic                  ser_busy,
  output logic                  ser_done
);

  ser_state_e            state_r;
  ser_state_e            state_nxt_s;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [CNTR_WIDTH-1:0] cnt_r;
  logic [CNTR_WIDTH-1:0] len_r;
  logic                  msbf_r;
  logic                  done_r;
  logic [CNTR_WIDTH-1:0] len_clamped_s;
  logic [DATA_WIDTH-1:0] load_word_s;
  logic                  accept_s;
  logic                  adv_s;
  logic                  last_s;

  assign len_clamped_s = CNTR_WIDTH'(clamp_len(32'(word_len), DATA_WIDTH));
  assign accept_s      = data_valid && (state_r == ST_IDLE);
  assign adv_s         = ser_en && (state_r == ST_SHIFT);
  assign last_s        = adv_s && (cnt_r == (len_r - CNTR_WIDTH'(1)));
  assign ser_done      = done_r;

  ser_len_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNTR_WIDTH (CNTR_WIDTH)
  ) u_align (
    .data_in   (data_in),
    .len       (len_clamped_s),
    .msb_first (msb_first),
    .load_word (load_word_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode; the serial bit is taken straight from the active end of the register.
  always_comb begin
    data_ready = 1'b0;
    ser_busy   = 1'b0;
    ser_data   = IDLE_LEVEL;
    case (state_r)
      ST_IDLE: begin
        data_ready = 1'b1;
        ser_busy   = 1'b0;
        ser_data   = IDLE_LEVEL;
      end
      ST_SHIFT: begin
        data_ready = 1'b0;
        ser_busy   = 1'b1;
        if (msbf_r) begin
          ser_data = shift_r[DATA_WIDTH-1];
        end else begin
          ser_data = shift_r[0];
        end
      end
      default: begin
        data_ready = 1'b0;
        ser_busy   = 1'b0;
        ser_data   = IDLE_LEVEL;
      end
    endcase
  end

  // Datapath: load on accept, shift on non-final strobes, pulse done on the final one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r <= {DATA_WIDTH{1'b0}};
      cnt_r   <= {CNTR_WIDTH{1'b0}};
      len_r   <= {CNTR_WIDTH{1'b0}};
      msbf_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= last_s;
      if (accept_s) begin
        shift_r <= load_word_s;
        cnt_r   <= {CNTR_WIDTH{1'b0}};
        len_r   <= len_clamped_s;
        msbf_r  <= msb_first;
      end else if (adv_s && !last_s) begin
        if (msbf_r) begin
          shift_r <= {shift_r[DATA_WIDTH-2:0], 1'b0};
        end else begin
          shift_r <= {1'b0, shift_r[DATA_WIDTH-1:1]};
        end
        cnt_r <= cnt_r + CNTR_WIDTH'(1);
      end else begin
        shift_r <= shift_r;
        cnt_r   <= cnt_r;
      end
    end
  end

`ifdef SER_PARITY_EN
  logic par_r;

  assign par_bit = par_r;

  // Parity over the bits actually sent, captured at accept and held until the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_r <= 1'b0;
    end else if (accept_s) begin
      par_r <= masked_parity(MAX_DATA_WIDTH'(data_in), 32'(len_clamped_s)) ^ par_odd;
    end else begin
      par_r <= par_r;
    end
  end
`endif

endmodule

// File: tb/tb_ser_shift_ctrl.sv
// Directed self-checking bench for ser_shift_ctrl (parity checks built when SER_PARITY_EN is defined).
module tb_ser_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic [3:0] word_len;
  logic       msb_first;
  logic       ser_en;
  logic       ser_data;
  logic       ser_busy;
  logic       ser_done;
`ifdef SER_PARITY_EN
  logic       par_odd;
  logic       par_bit;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ser_shift_ctrl #(
    .DATA_WIDTH (8),
    .CNTR_WIDTH (4),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .word_len   (word_len),
    .msb_first  (msb_first),
    .ser_en     (ser_en),
`ifdef SER_PARITY_EN
    .par_odd    (par_odd),
    .par_bit    (par_bit),
`endif
    .ser_data   (ser_data),
    .ser_busy   (ser_busy),
    .ser_done   (ser_done)
  );

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_data"}, ser_data, 1'b1);
    check_eq({tag, "_ready"}, data_ready, 1'b1);
    check_eq({tag, "_busy"}, ser_busy, 1'b0);
  endtask

  // Called at a negedge while in SHIFT; exp[i] is the i-th bit on the line.
  // Returns at the negedge right after the final strobe (the ser_done cycle).
  task automatic shift_word(input logic [15:0] exp, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("bit%0d", i), ser_data, exp[i]);
      check_eq($sformatf("busy%0d", i), ser_busy, 1'b1);
      repeat (gap) begin
        @(negedge clk);
        check_eq($sformatf("hold%0d", i), ser_data, exp[i]);
      end
      ser_en = 1'b1;
      @(negedge clk);
      ser_en = 1'b0;
      if (i < n - 1) begin
        check_eq($sformatf("done_early%0d", i), ser_done, 1'b0);
      end
    end
    check_eq("done_pulse", ser_done, 1'b1);
    check_idle("after_last");
  endtask

  task automatic send_word(input logic [7:0] d, input logic [3:0] len, input logic msbf,
                           input logic [15:0] exp, input int n, input int gap);
    data_in    = d;
    word_len   = len;
    msb_first  = msbf;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check_eq("ready_low", data_ready, 1'b0);
    shift_word(exp, n, gap);
    @(negedge clk);
    check_eq("done_one_cycle", ser_done, 1'b0);
    check_idle("idle_after");
  endtask

  initial begin
    rst        = 1'b0;
    data_in    = 8'h00;
    data_valid = 1'b0;
    word_len   = 4'd0;
    msb_first  = 1'b0;
    ser_en     = 1'b0;
`ifdef SER_PARITY_EN
    par_odd    = 1'b0;
`endif

    // Reset held three cycles, then strobes while idle do nothing.
    repeat (3) @(negedge clk);
    check_idle("rst");
    check_eq("rst_done", ser_done, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ser_en = 1'b1;
      @(negedge clk);
      ser_en = 1'b0;
      @(negedge clk);
      check_idle("idle_en");
      check_eq("idle_en_done", ser_done, 1'b0);
    end

    // LSB-first 0xA5: 1,0,1,0,0,1,0,1 with a strobe every 16 clocks.
    send_word(8'hA5, 4'd8, 1'b0, 16'h00A5, 8, 15);
    // MSB-first 5 bits of 0xF3: 1,0,0,1,1.
    send_word(8'hF3, 4'd5, 1'b1, 16'h0019, 5, 2);
    // MSB-first 0xC4: 1,1,0,0,0,1,0,0.
    send_word(8'hC4, 4'd8, 1'b1, 16'h0023, 8, 1);
    // LSB-first 3 bits of 0xFA: 0,1,0; upper ones never sent.
    send_word(8'hFA, 4'd3, 1'b0, 16'h0002, 3, 1);
    // word_len 0 clamps to a single bit.
    send_word(8'h01, 4'd0, 1'b0, 16'h0001, 1, 2);
    // word_len 15 clamps to 8 bits of 0x3C: 0,0,1,1,1,1,0,0.
    send_word(8'h3C, 4'd15, 1'b0, 16'h003C, 8, 0);

    // Back-to-back with valid held; new data during SHIFT must be ignored.
    data_in    = 8'h0F;
    word_len   = 4'd8;
    msb_first  = 1'b0;
    data_valid = 1'b1;
    @(negedge clk);
    data_in    = 8'hF0;
    word_len   = 4'd2;
    check_eq("b2b_ready", data_ready, 1'b0);
    shift_word(16'h000F, 8, 1);
    word_len = 4'd8;
    @(negedge clk);
    check_eq("b2b_accept_busy", ser_busy, 1'b1);
    check_eq("b2b_accept_done", ser_done, 1'b0);
    data_valid = 1'b0;
    shift_word(16'h00F0, 8, 0);
    @(negedge clk);
    check_eq("b2b_done_clear", ser_done, 1'b0);

    // Asynchronous reset after the third bit discards the word.
    data_in    = 8'h55;
    word_len   = 4'd8;
    msb_first  = 1'b0;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (3) begin
      ser_en = 1'b1;
      @(negedge clk);
      ser_en = 1'b0;
    end
    check_eq("mid_busy", ser_busy, 1'b1);
    check_eq("mid_bit3", ser_data, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_idle("mid_rst");
`ifdef SER_PARITY_EN
    check_eq("mid_rst_par", par_bit, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("post_rst");
    check_eq("post_rst_done", ser_done, 1'b0);

`ifdef SER_PARITY_EN
    par_odd = 1'b0;
    send_word(8'h07, 4'd8, 1'b0, 16'h0007, 8, 0);
    check_eq("par_even", par_bit, 1'b1);
    par_odd = 1'b1;
    send_word(8'h07, 4'd8, 1'b0, 16'h0007, 8, 0);
    check_eq("par_odd", par_bit, 1'b0);
`endif

    // A word sent after the reset shifts normally.
    send_word(8'h96, 4'd4, 1'b1, 16'h0006, 4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
